// File: rtl/branch_predictor_if.sv
// Lookup/update bundle between the pipeline and the branch predictor.
// The master side is the pipeline and the slave side is the predictor.
`timescale 1ns/1ps
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              flush;
  logic              mispredict;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush,
    input  pred_taken, pred_target, mispredict
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, flush,
    output pred_taken, pred_target, mispredict
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: combinational IF lookup, EX-stage training.
// Optional hit/miss statistics counters are enabled with BRANCH_PREDICTOR_STATS_EN.
`timescale 1ns/1ps
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predictor_if.slave    bus
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [CTR_W-1:0]   r_ctr    [ENTRIES];

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic               w_pred_taken;
  logic [ADDR_W-1:0]  w_pred_target;
  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic [CTR_W-1:0]   w_ctr_inc;
  logic [CTR_W-1:0]   w_ctr_dec;
  logic               w_mispredict;
  logic               w_unused_pc;

  // Word-offset bits never select an entry.
  assign w_unused_pc = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

  // Fetch-side lookup on registered state; no bypass from a same-cycle update.
  always_comb begin
    w_lk_idx = bus.if_pc[IDX_W+1:2];
    w_lk_tag = bus.if_pc[ADDR_W-1:IDX_W+2];
    w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    if (w_lk_hit && r_ctr[w_lk_idx][CTR_W-1]) begin
      w_pred_taken  = 1'b1;
      w_pred_target = r_target[w_lk_idx];
    end else begin
      w_pred_taken  = 1'b0;
      w_pred_target = bus.if_pc + ADDR_W'(32'd4);
    end
  end

  // Training-side entry match and saturated counter candidates.
  always_comb begin
    w_up_idx = bus.upd_pc[IDX_W+1:2];
    w_up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
    w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    if (r_ctr[w_up_idx] == CTR_MAX) begin
      w_ctr_inc = CTR_MAX;
    end else begin
      w_ctr_inc = r_ctr[w_up_idx] + CTR_W'(1);
    end
    if (r_ctr[w_up_idx] == CTR_MIN) begin
      w_ctr_dec = CTR_MIN;
    end else begin
      w_ctr_dec = r_ctr[w_up_idx] - CTR_W'(1);
    end
  end

  assign w_mispredict = bus.upd_valid &&
                        ((bus.upd_pred_taken != bus.upd_taken) ||
                         (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));

  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;
  assign bus.mispredict  = w_mispredict;

  // Table state: flush beats a same-cycle update; a not-taken miss never allocates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= {ADDR_W{1'b0}};
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (bus.flush) begin
      r_valid <= {ENTRIES{1'b0}};
    end else if (bus.upd_valid) begin
      if (w_up_hit) begin
        if (bus.upd_taken) begin
          r_ctr[w_up_idx]    <= w_ctr_inc;
          r_target[w_up_idx] <= bus.upd_target;
        end else begin
          r_ctr[w_up_idx]    <= w_ctr_dec;
        end
      end else if (bus.upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bus.upd_target;
        r_ctr[w_up_idx]    <= CTR_WT;
      end else begin
        r_valid <= r_valid;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Resolved-branch and mispredict counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else if (bus.flush) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else if (bus.upd_valid) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mispredict) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end else begin
        r_stat_mispredicts <= r_stat_mispredicts;
      end
    end else begin
      r_stat_branches    <= r_stat_branches;
      r_stat_mispredicts <= r_stat_mispredicts;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor (ENTRIES=16, CTR_W=2): lookup, training, aliasing, flush, reset.
`timescale 1ns/1ps
module tb_branch_predictor;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   exp_br;
  int   exp_mis;

  branch_predictor_if #(.ADDR_W(32)) bus ();

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus.slave)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc);
    bus.if_pc = pc;
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
    @(posedge clk);
    exp_br++;
    if ((ptk != tk) || (tk && (ptgt != tgt))) exp_mis++;
    #1;
    bus.upd_valid = 1'b0;
    bus.upd_pc    = 'x;
  endtask

  task automatic set_mis(input logic v, input logic ptk, input logic tk,
                         input logic [31:0] ptgt, input logic [31:0] tgt);
    bus.upd_valid       = v;
    bus.upd_pc          = 32'h0000_00C8;
    bus.upd_pred_taken  = ptk;
    bus.upd_taken       = tk;
    bus.upd_pred_target = ptgt;
    bus.upd_target      = tgt;
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; exp_br = 0; exp_mis = 0;
    reset = 1'b0;
    bus.if_pc = 32'h0000_0044;
    bus.upd_valid = 1'b0; bus.upd_pc = 'x; bus.upd_taken = 1'b0;
    bus.upd_target = 32'd0; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 32'd0;
    bus.flush = 1'b0;
    #1;
    chk("rst_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("rst_tgt", bus.pred_target, 32'h0000_0048);
    chk("rst_mis", {31'd0, bus.mispredict}, 32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    chk("rst_stat_br", stat_branches, 32'd0);
    chk("rst_stat_mis", stat_mispredicts, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    look(32'hFFFF_FFFC);
    chk("wrap_tgt", bus.pred_target, 32'h0000_0000);

    // First taken update with a same-cycle lookup of the same PC
    @(negedge clk);
    bus.if_pc = 32'h0000_0044;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_0044; bus.upd_taken = 1'b1;
    bus.upd_target = 32'h0000_0100; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 32'h0000_0048;
    #1;
    chk("same_cyc_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("same_cyc_mis", {31'd0, bus.mispredict}, 32'd1);
    @(posedge clk);
    exp_br++; exp_mis++;
    #1;
    bus.upd_valid = 1'b0; bus.upd_pc = 'x;
    #1;
    chk("alloc_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("alloc_tgt", bus.pred_target, 32'h0000_0100);

    // Decrement to zero, then saturate there
    do_upd(32'h44, 1'b0, 32'h998, 1'b1, 32'h100);
    look(32'h44);
    chk("nt1_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("nt1_tgt", bus.pred_target, 32'h0000_0048);
    do_upd(32'h44, 1'b0, 32'h998, 1'b0, 32'h48);
    for (int i = 0; i < 3; i++) do_upd(32'h44, 1'b0, 32'h998, 1'b0, 32'h48);
    do_upd(32'h44, 1'b1, 32'h140, 1'b0, 32'h48);
    look(32'h44);
    chk("sat0_pt", {31'd0, bus.pred_taken}, 32'd0);
    do_upd(32'h44, 1'b1, 32'h140, 1'b0, 32'h48);
    look(32'h44);
    chk("ctr2_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("ctr2_tgt", bus.pred_target, 32'h0000_0140);
    do_upd(32'h44, 1'b1, 32'h140, 1'b1, 32'h140);
    do_upd(32'h44, 1'b1, 32'h140, 1'b1, 32'h140);
    do_upd(32'h44, 1'b0, 32'h998, 1'b1, 32'h140);
    look(32'h44);
    chk("sat3_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("nt_keep_tgt", bus.pred_target, 32'h0000_0140);
    do_upd(32'h44, 1'b1, 32'h140, 1'b1, 32'h140);

    // Alias at index 1 with a different tag
    do_upd(32'h84, 1'b1, 32'h200, 1'b0, 32'h88);
    look(32'h44);
    chk("alias_old_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("alias_old_tgt", bus.pred_target, 32'h0000_0048);
    look(32'h84);
    chk("alias_new_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("alias_new_tgt", bus.pred_target, 32'h0000_0200);
    do_upd(32'h84, 1'b0, 32'h200, 1'b1, 32'h200);
    look(32'h84);
    chk("alloc_weak_pt", {31'd0, bus.pred_taken}, 32'd0);

    // Not-taken miss must not allocate
    do_upd(32'h44, 1'b0, 32'h500, 1'b0, 32'h48);
    look(32'h44);
    chk("nt_miss_pt", {31'd0, bus.pred_taken}, 32'd0);

    // Mispredict combinations; updates withdrawn before the edge
    @(negedge clk);
    set_mis(1'b1, 1'b1, 1'b1, 32'h100, 32'h104);
    chk("mis_tgt_diff", {31'd0, bus.mispredict}, 32'd1);
    set_mis(1'b1, 1'b1, 1'b1, 32'h100, 32'h100);
    chk("mis_tgt_same", {31'd0, bus.mispredict}, 32'd0);
    set_mis(1'b1, 1'b1, 1'b0, 32'h100, 32'h104);
    chk("mis_dir", {31'd0, bus.mispredict}, 32'd1);
    set_mis(1'b0, 1'b1, 1'b0, 32'h100, 32'h104);
    chk("mis_idle", {31'd0, bus.mispredict}, 32'd0);
    @(negedge clk);
    set_mis(1'b1, 1'b0, 1'b0, 32'h100, 32'h104);
    chk("mis_nt_nt", {31'd0, bus.mispredict}, 32'd0);
    bus.upd_valid = 1'b0; bus.upd_pc = 'x;
    look(32'hC8);
    chk("mis_no_upd_pt", {31'd0, bus.pred_taken}, 32'd0);

    do_upd(32'hC8, 1'b1, 32'h300, 1'b0, 32'hCC);
    look(32'hC8);
    chk("c8_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("c8_tgt", bus.pred_target, 32'h0000_0300);
`ifdef BRANCH_PREDICTOR_STATS_EN
    chk("pre_flush_br", stat_branches, 32'(exp_br));
    chk("pre_flush_mis", stat_mispredicts, 32'(exp_mis));
`endif

    // Flush with a same-cycle taken update
    @(negedge clk);
    bus.flush = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h44; bus.upd_taken = 1'b1;
    bus.upd_target = 32'h400; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 32'h48;
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.upd_valid = 1'b0; bus.upd_pc = 'x;
    look(32'hC8);
    chk("flush_c8_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("flush_c8_tgt", bus.pred_target, 32'h0000_00CC);
    look(32'h44);
    chk("flush_44_pt", {31'd0, bus.pred_taken}, 32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    chk("flush_stat_br", stat_branches, 32'd0);
    chk("flush_stat_mis", stat_mispredicts, 32'd0);
`endif

    // Five updates, two of them mispredicted
    do_upd(32'hC8, 1'b1, 32'h300, 1'b0, 32'hCC);
    do_upd(32'hC8, 1'b1, 32'h300, 1'b1, 32'h300);
    do_upd(32'hC8, 1'b0, 32'h300, 1'b1, 32'h300);
    do_upd(32'h44, 1'b0, 32'h300, 1'b0, 32'h48);
    do_upd(32'hC8, 1'b1, 32'h300, 1'b1, 32'h300);
    look(32'hC8);
    chk("five_c8_pt", {31'd0, bus.pred_taken}, 32'd1);
    chk("five_c8_tgt", bus.pred_target, 32'h0000_0300);
`ifdef BRANCH_PREDICTOR_STATS_EN
    chk("five_stat_br", stat_branches, 32'd5);
    chk("five_stat_mis", stat_mispredicts, 32'd2);
`endif

    // Reset asserted with an update in flight
    @(negedge clk);
    bus.if_pc = 32'hC8;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h44; bus.upd_taken = 1'b1;
    bus.upd_target = 32'h500; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 32'h48;
    reset = 1'b0;
    #1;
    chk("midrst_c8_pt", {31'd0, bus.pred_taken}, 32'd0);
`ifdef BRANCH_PREDICTOR_STATS_EN
    chk("midrst_stat_br", stat_branches, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1; bus.upd_valid = 1'b0; bus.upd_pc = 'x;
    look(32'h44);
    chk("midrst_44_pt", {31'd0, bus.pred_taken}, 32'd0);
    chk("midrst_44_tgt", bus.pred_target, 32'h0000_0048);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the pipelined MIPS-subset CPU.
- Looked up combinationally from the IF-stage PC; trained from the EX stage, where conditional branches resolve.
- Lets IF redirect to a predicted target. The CPU then flushes only on mispredict, instead of on every taken branch.
- Direct-mapped, table depth and counter width configurable.

Parameters:
- ENTRIES, 16: table depth; power of two, ≥2; IDX_W = log2(ENTRIES).
- ADDR_W, 32: PC width; PC[1:0] is ignored (word-aligned).
- CTR_W, 2: direction counter width, 1..4.
- TAG_W is derived, not a parameter: ADDR_W-IDX_W-2.

Ports:
- clk  in  1  core clock (same divided clock as the pipeline)
- reset  in  1  asynchronous, active-low reset
- if_pc  in  ADDR_W  IF-stage fetch PC
- pred_taken  out  1  lookup hit and counter MSB = 1
- pred_target  out  ADDR_W  stored target on hit, else if_pc+4
- upd_valid  in  1  EX resolved a conditional branch this cycle
- upd_pc  in  ADDR_W  PC of the resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual branch target (ConBA)
- upd_pred_taken  in  1  prediction that was carried down the pipe with this branch
- upd_pred_target  in  ADDR_W  predicted target carried down the pipe
- flush  in  1  synchronous invalidate of all entries (context switch / table reset)
- mispredict  out  1  combinational; upd_valid and (upd_pred_taken≠upd_taken, or upd_taken and upd_pred_target≠upd_target)

Behaviour:
- Entry i fields: valid, tag[TAG_W], target[ADDR_W], ctr[CTR_W].
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- Reset (async, reset=0), for all entries:
  - valid=0, tag=0, target=0, ctr=2^(CTR_W-1)-1 (weakly not-taken).
  - Outputs settle to pred_taken=0, pred_target=if_pc+4, mispredict=0 (the last only while upd_valid=0).
- Lookup is purely combinational on registered state; zero latency.
  - hit = valid[idx] and tag[idx]==tag(if_pc).
  - pred_taken = hit and ctr[idx][CTR_W-1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, computed mod 2^ADDR_W (wraps).
- Update at posedge clk when upd_valid=1 and flush=0. Let u = index(upd_pc), uhit = valid[u] and tag match.
  - uhit, taken: ctr increments, saturating at 2^CTR_W-1; target <= upd_target.
  - uhit, not taken: ctr decrements, saturating at 0; target unchanged.
  - miss, taken: allocate, overwriting any aliased entry: valid=1, tag=tag(upd_pc), target=upd_target, ctr=2^(CTR_W-1) (weakly taken).
  - miss, not taken: no change; no allocation.
- flush=1 at posedge: all valid <= 0; ctr/tag/target unchanged. flush takes priority over a same-cycle update, so that update is dropped.
- Simultaneous lookup and update of the same index: lookup returns the pre-update value; there is no write-through bypass. The new value is visible the next cycle.
- One update per cycle maximum. If upd_pc is X while upd_valid=0, the table must not change.
- Reset asserted mid-operation: table is cleared immediately; any in-flight update is lost.
- CTR_W=1: counter is a last-outcome bit. Allocation value is 1; not-taken clears it.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Both reset to 0; cleared by flush.
  - Each increments by 1 at posedge when upd_valid=1; stat_mispredicts additionally requires mispredict=1.
  - Both wrap at 2^32.
  - Counting applies even when flush is not asserted and the update is otherwise accepted.
- Undefined: the ports do not exist, and no counter logic is synthesised.

Test Plan (ENTRIES=16, CTR_W=2):
- Reset, if_pc=0x0000_0044 -> pred_taken=0, pred_target=0x0000_0048.
- Update pc=0x44, taken, target=0x100 -> next cycle if_pc=0x44 gives pred_taken=1, pred_target=0x100 (ctr=2).
  - Then 2 not-taken updates -> ctr=0, pred_taken=0.
  - Then 3 more not-taken -> ctr stays 0.
- Entry 0x44 trained to ctr=3. Update pc=0x84 (same index 1, tag 2), taken, target=0x200.
  - if_pc=0x44 -> miss, pred_taken=0.
  - if_pc=0x84 -> pred_taken=1, target 0x200.
- Same cycle: if_pc=0x44 lookup, and first taken update of 0x44 -> pred_taken=0 that cycle, 1 the next.
- Miss, not-taken update of 0x44 -> no allocation; lookup still misses.
  - Also: upd_pred_taken=1, upd_taken=1, targets 0x100 vs 0x104 -> mispredict=1.
- flush together with a taken update of 0x44 -> all lookups miss next cycle; update dropped.
  - With BRANCH_PREDICTOR_STATS_EN: 5 updates incl. 2 mispredicts -> stat_branches=5, stat_mispredicts=2; both 0 after flush.
